// File: rtl/output_holder_ctrl_pkg.sv
// Shared types and defaults for the stream-cipher output holder.
package output_holder_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    READY    = 2'd1,
    ACK_WAIT = 2'd2
  } output_holder_state_t;

  localparam int DEFAULT_DEPTH       = 2;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/output_holder_ctrl_if.sv
// Byte handshake from the cipher core into the output holder FIFO.
interface output_holder_ctrl_if;

  logic [7:0] byte_in;
  logic       byte_in_valid;
  logic       byte_in_ready;

  modport master (output byte_in, output byte_in_valid, input  byte_in_ready);
  modport slave  (input  byte_in, input  byte_in_valid, output byte_in_ready);

endinterface

// File: rtl/output_holder_ctrl_sync_ff.sv
// N-stage reset-to-zero synchronizer for an asynchronous input pin.
module output_holder_ctrl_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/output_holder_ctrl.sv
// Buffers cipher output bytes and holds the head byte until the chip user
// acknowledges it with a rising edge on the asynchronous ack pin.
module output_holder_ctrl
  import output_holder_ctrl_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output_holder_ctrl_if.slave         in_if,
  input  logic                        flush,
  input  logic                        output_acknowledge,
  output logic [7:0]                  data_out,
  output output_holder_state_t        state,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]           mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  output_holder_state_t state_q, state_d;
  logic [7:0]           data_out_q, data_out_d;
  logic                 ack_q, ack_d;
  logic                 ack_s;
  logic                 ack_rise;
  logic                 push;
  logic                 pop;
  logic                 ready;

  output_holder_ctrl_sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (output_acknowledge),
    .q     (ack_s)
  );

  assign ready    = (count_q < CNT_W'(DEPTH)) && !flush;
  assign push     = in_if.byte_in_valid && ready;
  assign ack_rise = ack_s & ~ack_q;
  // Acks are only honoured in READY, so an empty FIFO can never be popped.
  assign pop      = (state_q == READY) && ack_rise && !flush;

  always_comb begin
    ack_d      = ack_s;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    state_d    = state_q;
    data_out_d = 8'h00;

    case (state_q)
      EMPTY:    if (count_q != '0) state_d = READY;
      READY:    if (pop)           state_d = ACK_WAIT;
      ACK_WAIT: if (!ack_s)        state_d = (count_d != '0) ? READY : EMPTY;
      default:                     state_d = EMPTY;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = EMPTY;
    end

    // A byte pushed on the same edge that re-enters READY is not yet in
    // storage, so it is forwarded straight from the input.
    if (state_d == READY)
      data_out_d = (count_q == '0) ? in_if.byte_in : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= EMPTY;
      data_out_q <= 8'h00;
      ack_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      data_out_q <= data_out_d;
      ack_q      <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.byte_in;
  end

  assign in_if.byte_in_ready = ready;
  assign data_out            = data_out_q;
  assign state               = state_q;
  assign count               = count_q;

endmodule

// File: tb/tb_output_holder_ctrl.sv
// Directed bench for output_holder_ctrl: handshake, ack sequencing, flush, reset.
module tb_output_holder_ctrl;
  import output_holder_ctrl_pkg::*;

  localparam int DEPTH = 2;
  localparam int SYNC  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic                 output_acknowledge;
  logic [7:0]           data_out;
  output_holder_state_t state;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  output_holder_ctrl_if in_if ();

  output_holder_ctrl #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_if              (in_if.slave),
    .flush              (flush),
    .output_acknowledge (output_acknowledge),
    .data_out           (data_out),
    .state              (state),
    .count              (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_if.byte_in       = b;
    in_if.byte_in_valid = 1'b1;
    tick(1);
    in_if.byte_in_valid = 1'b0;
  endtask

  task automatic drain_one();
    output_acknowledge = 1'b1;
    tick(SYNC + 1);
    output_acknowledge = 1'b0;
    tick(SYNC + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; output_acknowledge = 1'b0;
    in_if.byte_in = 8'h00; in_if.byte_in_valid = 1'b0;
    #12;
    total++; if (state !== EMPTY) begin bad++; $display("FAIL reset_state: got %0d required %0d", state, EMPTY); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d required 0", count); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h required 00", data_out); end
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    total++; if (in_if.byte_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", in_if.byte_in_ready); end
  endtask

  task automatic test_single();
    push_byte(8'hA5);
    total++; if (count !== 2'd1 || state !== EMPTY) begin bad++; $display("FAIL single_push: got count=%0d state=%0d required 1/EMPTY", count, state); end
    tick(1);
    total++; if (state !== READY || data_out !== 8'hA5) begin bad++; $display("FAIL single_ready: got state=%0d data=%h required READY/a5", state, data_out); end
    output_acknowledge = 1'b1;
    tick(SYNC);
    total++; if (state !== READY || count !== 2'd1) begin bad++; $display("FAIL single_early_pop: got state=%0d count=%0d required READY/1", state, count); end
    tick(1);
    total++; if (state !== ACK_WAIT || data_out !== 8'h00 || count !== 2'd0) begin bad++; $display("FAIL single_pop: got state=%0d data=%h count=%0d required ACK_WAIT/00/0", state, data_out, count); end
    output_acknowledge = 1'b0;
    tick(SYNC + 1);
    total++; if (state !== EMPTY || count !== 2'd0) begin bad++; $display("FAIL single_empty: got state=%0d count=%0d required EMPTY/0", state, count); end
  endtask

  task automatic test_full();
    push_byte(8'h11);
    push_byte(8'h22);
    total++; if (count !== 2'd2 || in_if.byte_in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got count=%0d ready=%b required 2/0", count, in_if.byte_in_ready); end
    push_byte(8'h33);
    total++; if (count !== 2'd2 || data_out !== 8'h11) begin bad++; $display("FAIL full_hold: got count=%0d data=%h required 2/11", count, data_out); end
    output_acknowledge = 1'b1;
    tick(SYNC + 1);
    total++; if (count !== 2'd1 || state !== ACK_WAIT) begin bad++; $display("FAIL full_pop: got count=%0d state=%0d required 1/ACK_WAIT", count, state); end
    output_acknowledge = 1'b0;
    tick(SYNC + 1);
    total++; if (state !== READY || data_out !== 8'h22 || in_if.byte_in_ready !== 1'b1) begin bad++; $display("FAIL full_next: got state=%0d data=%h ready=%b required READY/22/1", state, data_out, in_if.byte_in_ready); end
    drain_one();
    total++; if (state !== EMPTY || count !== 2'd0) begin bad++; $display("FAIL full_drain: got state=%0d count=%0d required EMPTY/0", state, count); end
  endtask

  task automatic test_ack_held();
    output_acknowledge = 1'b1;
    tick(SYNC + 2);
    push_byte(8'h5C);
    tick(1);
    total++; if (state !== READY || data_out !== 8'h5C) begin bad++; $display("FAIL held_ready: got state=%0d data=%h required READY/5c", state, data_out); end
    tick(4);
    total++; if (state !== READY || count !== 2'd1) begin bad++; $display("FAIL held_nopop: got state=%0d count=%0d required READY/1", state, count); end
    output_acknowledge = 1'b0;
    tick(SYNC + 1);
    output_acknowledge = 1'b1;
    tick(SYNC + 1);
    total++; if (state !== ACK_WAIT || count !== 2'd0) begin bad++; $display("FAIL held_repop: got state=%0d count=%0d required ACK_WAIT/0", state, count); end
    output_acknowledge = 1'b0;
    tick(SYNC + 1);
  endtask

  task automatic test_push_pop();
    push_byte(8'h66);
    tick(1);
    total++; if (state !== READY || data_out !== 8'h66) begin bad++; $display("FAIL pp_ready: got state=%0d data=%h required READY/66", state, data_out); end
    output_acknowledge = 1'b1;
    tick(SYNC);
    push_byte(8'h77);
    total++; if (count !== 2'd1 || state !== ACK_WAIT) begin bad++; $display("FAIL pp_same_edge: got count=%0d state=%0d required 1/ACK_WAIT", count, state); end
    output_acknowledge = 1'b0;
    tick(SYNC + 1);
    total++; if (state !== READY || data_out !== 8'h77) begin bad++; $display("FAIL pp_next: got state=%0d data=%h required READY/77", state, data_out); end
    drain_one();
  endtask

  task automatic test_flush();
    push_byte(8'hAA);
    push_byte(8'hBB);
    total++; if (count !== 2'd2 || state !== READY) begin bad++; $display("FAIL flush_pre: got count=%0d state=%0d required 2/READY", count, state); end
    flush = 1'b1;
    push_byte(8'hCC);
    flush = 1'b0;
    total++; if (count !== 2'd0 || state !== EMPTY || data_out !== 8'h00) begin bad++; $display("FAIL flush_clear: got count=%0d state=%0d data=%h required 0/EMPTY/00", count, state, data_out); end
    tick(1);
    total++; if (count !== 2'd0) begin bad++; $display("FAIL flush_nostore: got count=%0d required 0", count); end
    push_byte(8'hDD);
    tick(1);
    total++; if (state !== READY || data_out !== 8'hDD) begin bad++; $display("FAIL flush_after: got state=%0d data=%h required READY/dd", state, data_out); end
    drain_one();
  endtask

  task automatic test_midreset();
    push_byte(8'hE1);
    push_byte(8'hE2);
    #2 rst_n = 1'b0;
    #1;
    total++; if (count !== 2'd0 || state !== EMPTY || data_out !== 8'h00) begin bad++; $display("FAIL midrst_async: got count=%0d state=%0d data=%h required 0/EMPTY/00", count, state, data_out); end
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    push_byte(8'hC3);
    tick(1);
    total++; if (state !== READY || data_out !== 8'hC3 || count !== 2'd1) begin bad++; $display("FAIL midrst_after: got state=%0d data=%h count=%0d required READY/c3/1", state, data_out, count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_ack_held();
    test_push_pop();
    test_flush();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
